// File: rtl/serial_sub_ctrl_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : serial_sub_ctrl_pkg
// Description : Shared state encoding for the bit-serial subtraction
//               controller (IDLE=0, RUN=1, DONE=2; code 3 is illegal).
// Revision    : 1.0 - initial release
// ============================================================================
package serial_sub_ctrl_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage : serial_sub_ctrl_pkg
`default_nettype wire

// File: rtl/full_sub_1bit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : full_sub_1bit
// Description : 1-bit full subtractor cell computing x - y - bin.
// Revision    : 1.0 - initial release
// ============================================================================
module full_sub_1bit (
  output logic d,
  output logic bout,
  input  logic x,
  input  logic y,
  input  logic bin
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~x & bin) | (y & bin);

endmodule : full_sub_1bit
`default_nettype wire

// File: rtl/serial_sub_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : serial_sub_ctrl
// Description : Bit-serial A - B controller. One shared full-subtractor cell
//               is sequenced over WIDTH cycles, LSB first, with a registered
//               borrow. start/busy/done handshake, one operation at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_sub_ctrl
  import serial_sub_ctrl_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  // Only the upper WIDTH-1 result bits need storage: the final bit comes
  // straight from the cell on the last RUN cycle.
  logic [WIDTH-2:0] sr;
  logic [WIDTH-1:0] res;
  logic             brw;
  logic [CW-1:0]    cnt;
  logic             cell_d;
  logic             cell_bout;
  logic             last;

  full_sub_1bit u_cell (
    .d    (cell_d),
    .bout (cell_bout),
    .x    (sa[0]),
    .y    (sb[0]),
    .bin  (brw)
  );

  assign last = (cnt == CNT_LAST);
  assign res  = {cell_d, sr};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and decoded status outputs (busy/done follow the registered state).
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (last) state_nxt = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand shifters, borrow chain, bit counter and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa         <= '0;
      sb         <= '0;
      sr         <= '0;
      brw        <= 1'b0;
      cnt        <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            sa  <= a;
            sb  <= b;
            brw <= 1'b0;
            cnt <= '0;
          end
        end
        S_RUN: begin
          sa  <= {1'b0, sa[WIDTH-1:1]};
          sb  <= {1'b0, sb[WIDTH-1:1]};
          sr  <= res[WIDTH-1:1];
          brw <= cell_bout;
          if (last) begin
            diff       <= res;
            borrow_out <= cell_bout;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule : serial_sub_ctrl
`default_nettype wire

// File: tb/tb_serial_sub_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_serial_sub_ctrl
// Description : Self-checking bench for serial_sub_ctrl (WIDTH=3 and WIDTH=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_sub_ctrl;

  localparam int W3 = 3;
  localparam int W8 = 8;

  logic          clk;
  logic          rst;
  logic          start3;
  logic [W3-1:0] a3, b3;
  logic          busy3, done3, brw3;
  logic [W3-1:0] diff3;
  logic          start8;
  logic [W8-1:0] a8, b8;
  logic          busy8, done8, brw8;
  logic [W8-1:0] diff8;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 0;

  serial_sub_ctrl #(.WIDTH(W3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .a(a3), .b(b3),
    .busy(busy3), .done(done3), .diff(diff3), .borrow_out(brw3)
  );

  serial_sub_ctrl #(.WIDTH(W8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow_out(brw8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model for the WIDTH=3 instance: an operation is a count of
  // cycles since acceptance; phases 1..W3 are busy computing, phase W3+1 is
  // the done cycle, and the result is plain unsigned arithmetic.
  int            ph;
  logic [W3-1:0] m_pend, m_diff;
  logic          m_pb, m_brw;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ph = 0; m_diff = '0; m_brw = 1'b0; m_pend = '0; m_pb = 1'b0;
    end else if (ph == 0) begin
      if (start3) begin
        ph     = 1;
        m_pend = W3'(a3 - b3);
        m_pb   = (a3 < b3);
      end
    end else if (ph == W3) begin
      ph     = W3 + 1;
      m_diff = m_pend;
      m_brw  = m_pb;
    end else if (ph == W3 + 1) begin
      ph = 0;
    end else begin
      ph = ph + 1;
    end
  end

  // Cycle-by-cycle comparison of the WIDTH=3 instance against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cmp_busy", 32'(busy3), 32'(ph != 0));
      chk("cmp_done", 32'(done3), 32'(ph == W3 + 1));
      chk("cmp_diff", 32'(diff3), 32'(m_diff));
      chk("cmp_borrow", 32'(brw3), 32'(m_brw));
    end
  end

  // Called right after the accepting edge; waits for done on the selected instance.
  task automatic wait_done3(input string name, input logic [W3-1:0] ed, input logic eb);
    int n = 1;
    while (done3 !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk({name, "_latency"}, 32'(n), 32'(W3 + 1));
    chk({name, "_diff"}, 32'(diff3), 32'(ed));
    chk({name, "_borrow"}, 32'(brw3), 32'(eb));
  endtask

  task automatic op3(input string name, input logic [W3-1:0] ia, input logic [W3-1:0] ib,
                     input logic [W3-1:0] ed, input logic eb);
    start3 = 1'b1; a3 = ia; b3 = ib;
    step();
    start3 = 1'b0; a3 = '0; b3 = '0;
    wait_done3(name, ed, eb);
    step();
  endtask

  initial begin
    int n;
    rst = 1'b1; start3 = 1'b0; a3 = '0; b3 = '0;
    start8 = 1'b0; a8 = '0; b8 = '0;
    step();
    step();
    chk("reset_busy", 32'(busy3), 32'd0);
    chk("reset_done", 32'(done3), 32'd0);
    chk("reset_diff", 32'(diff3), 32'd0);
    chk("reset_borrow", 32'(brw3), 32'd0);
    rst = 1'b0;
    chk_en = 1'b1;
    step();

    // Directed cases with literal expectations.
    op3("sub_5_3", 3'd5, 3'd3, 3'b010, 1'b0);
    op3("sub_0_4", 3'd0, 3'd4, 3'b100, 1'b1);
    op3("sub_2_5", 3'd2, 3'd5, 3'b101, 1'b1);
    op3("sub_7_7", 3'd7, 3'd7, 3'd0, 1'b0);
    op3("sub_7_0", 3'd7, 3'd0, 3'd7, 1'b0);

    // start held high through RUN and DONE is ignored; next IDLE start accepted.
    start3 = 1'b1; a3 = 3'd6; b3 = 3'd1;
    step();
    a3 = 3'd1; b3 = 3'd6;
    step(); step(); step();
    chk("ign_done", 32'(done3), 32'd1);
    chk("ign_diff", 32'(diff3), 32'd5);
    chk("ign_borrow", 32'(brw3), 32'd0);
    step();
    chk("ign_idle_busy", 32'(busy3), 32'd0);
    chk("ign_idle_diff", 32'(diff3), 32'd5);
    step();
    start3 = 1'b0; a3 = '0; b3 = '0;
    chk("ign_next_busy", 32'(busy3), 32'd1);
    wait_done3("ign_next", 3'b011, 1'b1);
    step();

    // Reset mid-RUN aborts immediately with no done pulse.
    start3 = 1'b1; a3 = 3'd4; b3 = 3'd1;
    step();
    start3 = 1'b0;
    step();
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy3), 32'd0);
    chk("abort_done", 32'(done3), 32'd0);
    chk("abort_diff", 32'(diff3), 32'd0);
    chk("abort_borrow", 32'(brw3), 32'd0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("abort_no_done", 32'(done3), 32'd0);
    end
    op3("after_abort", 3'd4, 3'd1, 3'd3, 1'b0);

    // Exhaustive WIDTH=3 sweep against plain unsigned arithmetic.
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        op3("sweep", 3'(i), 3'(j), 3'(i - j), (i < j));
      end
    end

    // WIDTH=8 spot checks.
    start8 = 1'b1; a8 = 8'h10; b8 = 8'h01;
    step();
    start8 = 1'b0; a8 = '0; b8 = '0;
    n = 1;
    while (done8 !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk("w8_latency", 32'(n), 32'd9);
    chk("w8_diff", 32'(diff8), 32'h0F);
    chk("w8_borrow", 32'(brw8), 32'd0);
    step();
    chk("w8_idle_busy", 32'(busy8), 32'd0);
    chk("w8_hold_diff", 32'(diff8), 32'h0F);

    start8 = 1'b1; a8 = 8'h01; b8 = 8'h10;
    step();
    start8 = 1'b0;
    n = 1;
    while (done8 !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk("w8b_latency", 32'(n), 32'd9);
    chk("w8b_diff", 32'(diff8), 32'hF1);
    chk("w8b_borrow", 32'(brw8), 32'd1);
    step();

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_serial_sub_ctrl
`default_nettype wire
